// File: rtl/fifo_sim_pkg.sv
// rtl/fifo_sim_pkg.sv - shared types for the FIFO read-side stream consumer
package fifo_sim_pkg;
    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } rd_state_t;
endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - 2-entry valid/ready buffer; entry 0 drives the output
module skid_buf2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] d0, d1;
    logic         v0, v1;
    logic         acc, push;

    // Room exists unless both entries stay occupied after this cycle's accept.
    assign in_ready  = ~v1 | out_ready;
    assign acc       = v0 & out_ready;
    assign push      = in_valid & in_ready;
    assign out_valid = v0;
    assign out_data  = d0;

    always_ff @(posedge clk) begin
        if (rst) begin
            d0 <= '0;
            d1 <= '0;
            v0 <= 1'b0;
            v1 <= 1'b0;
        end else if (acc) begin
            if (v1) begin
                d0 <= d1;
                v0 <= 1'b1;
                if (push) begin
                    d1 <= in_data;
                end
                v1 <= push;
            end else begin
                if (push) begin
                    d0 <= in_data;
                end
                v0 <= push;
            end
        end else if (push) begin
            if (!v0) begin
                d0 <= in_data;
                v0 <= 1'b1;
            end else begin
                d1 <= in_data;
                v1 <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - pops a FWFT FIFO into a valid/ready stream with flush and word count
module fifo_rd_stream
    import fifo_sim_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int CNTSIZE  = 16
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic [DATASIZE-1:0] RDATA_I,
    input  logic                REMPTY_I,
    input  logic                AREMPTY_I,
    output logic                RINC_O,
    input  logic                ENABLE_I,
    input  logic                FLUSH_I,
    output logic [DATASIZE-1:0] M_DATA_O,
    output logic                M_VALID_O,
    input  logic                M_READY_I,
    output logic                LOW_WATER_O,
    output logic                BUSY_O,
    output logic [CNTSIZE-1:0]  RD_CNT_O
);
    rd_state_t          state, state_d;
    logic               skid_ready;
    logic               push;
    logic               rinc;
    logic               low_water_q, busy_q;
    logic [CNTSIZE-1:0] cnt_q;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state       <= ST_IDLE;
            low_water_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state       <= state_d;
            low_water_q <= AREMPTY_I;
            busy_q      <= (state_d == ST_FLUSH);
            if (M_VALID_O && M_READY_I) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        rinc    = 1'b0;
        push    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (FLUSH_I) begin
                    state_d = ST_FLUSH;
                end else if (ENABLE_I) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                rinc = ENABLE_I & ~REMPTY_I & skid_ready;
                push = rinc;
                if (FLUSH_I) begin
                    state_d = ST_FLUSH;
                end else if (!ENABLE_I) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // Popped words bypass the skid buffer and are dropped.
                rinc = ~REMPTY_I;
                if (REMPTY_I) begin
                    state_d = ENABLE_I ? ST_RUN : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (RST_I) begin
            rinc = 1'b0;
            push = 1'b0;
        end
    end

    skid_buf2 #(.W(DATASIZE)) u_skid (
        .clk       (CLK_I),
        .rst       (RST_I),
        .in_valid  (push),
        .in_ready  (skid_ready),
        .in_data   (RDATA_I),
        .out_valid (M_VALID_O),
        .out_ready (M_READY_I),
        .out_data  (M_DATA_O)
    );

    assign RINC_O      = rinc;
    assign LOW_WATER_O = low_water_q;
    assign BUSY_O      = busy_q;
    assign RD_CNT_O    = cnt_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed bench for fifo_rd_stream with a queue-backed FIFO model
module tb_fifo_rd_stream;
    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b1;
    logic [7:0] RDATA_I = 8'h00;
    logic       REMPTY_I = 1'b1;
    logic       AREMPTY_I = 1'b1;
    logic       RINC_O;
    logic       ENABLE_I = 1'b0;
    logic       FLUSH_I = 1'b0;
    logic [7:0] M_DATA_O;
    logic       M_VALID_O;
    logic       M_READY_I = 1'b0;
    logic       LOW_WATER_O;
    logic       BUSY_O;
    logic [3:0] RD_CNT_O;

    fifo_rd_stream #(.DATASIZE(8), .CNTSIZE(4)) dut (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .RDATA_I     (RDATA_I),
        .REMPTY_I    (REMPTY_I),
        .AREMPTY_I   (AREMPTY_I),
        .RINC_O      (RINC_O),
        .ENABLE_I    (ENABLE_I),
        .FLUSH_I     (FLUSH_I),
        .M_DATA_O    (M_DATA_O),
        .M_VALID_O   (M_VALID_O),
        .M_READY_I   (M_READY_I),
        .LOW_WATER_O (LOW_WATER_O),
        .BUSY_O      (BUSY_O),
        .RD_CNT_O    (RD_CNT_O)
    );

    always #5 CLK_I = ~CLK_I;

    int         total = 0;
    int         bad = 0;
    logic [7:0] q[$];
    logic [7:0] rx[$];
    logic [7:0] exp_q[$];
    logic       force_empty = 1'b0;
    int         tick_no = 0;
    int         npop = 0;
    int         pop_first = -1, pop_last = -1;
    int         acc_first = -1, acc_last = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_fifo();
        REMPTY_I  = (q.size() == 0) || force_empty;
        AREMPTY_I = (q.size() <= 2) || force_empty;
        RDATA_I   = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic clear_stats();
        rx.delete();
        npop = 0;
        pop_first = -1; pop_last = -1;
        acc_first = -1; acc_last = -1;
    endtask

    task automatic tick();
        logic       pop, acc, lw, rst_s;
        logic [7:0] d, dummy;
        @(negedge CLK_I);
        pop   = RINC_O;
        acc   = M_VALID_O && M_READY_I;
        d     = M_DATA_O;
        lw    = AREMPTY_I;
        rst_s = RST_I;
        check("rinc_while_empty", {31'd0, pop && REMPTY_I}, 32'd0);
        if (pop) begin
            npop++;
            if (pop_first < 0) pop_first = tick_no;
            pop_last = tick_no;
        end
        if (acc) begin
            rx.push_back(d);
            if (acc_first < 0) acc_first = tick_no;
            acc_last = tick_no;
        end
        @(posedge CLK_I);
        #1;
        tick_no++;
        if (pop && q.size() > 0) dummy = q.pop_front();
        drive_fifo();
        if (!rst_s) check("low_water", {31'd0, LOW_WATER_O}, {31'd0, lw});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_len"}, rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
            check(tag, {24'd0, rx[i]}, {24'd0, exp_q[i]});
    endtask

    initial begin
        // 1: reset with a non-empty FIFO, then quiet in IDLE
        q = '{8'h55};
        drive_fifo();
        RST_I = 1'b1;
        ticks(3);
        check("rst_valid", {31'd0, M_VALID_O}, 32'd0);
        check("rst_data", {24'd0, M_DATA_O}, 32'd0);
        check("rst_rinc", {31'd0, RINC_O}, 32'd0);
        check("rst_busy", {31'd0, BUSY_O}, 32'd0);
        check("rst_lw", {31'd0, LOW_WATER_O}, 32'd0);
        check("rst_cnt", {28'd0, RD_CNT_O}, 32'd0);
        RST_I = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_rinc", {31'd0, RINC_O}, 32'd0);
            check("idle_valid", {31'd0, M_VALID_O}, 32'd0);
        end
        q.delete();
        drive_fifo();
        tick();

        // 2: streaming 0x01..0x08
        clear_stats();
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        drive_fifo();
        ENABLE_I = 1'b1;
        M_READY_I = 1'b1;
        ticks(12);
        check("stream_pops", npop, 8);
        check("stream_pop_span", pop_last - pop_first, 7);
        check("stream_acc_span", acc_last - acc_first, 7);
        check("stream_latency", acc_first - pop_first, 1);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        check_rx("stream_data");
        check("stream_cnt", {28'd0, RD_CNT_O}, 32'd8);

        // 3: backpressure 0xA0..0xA5
        clear_stats();
        M_READY_I = 1'b0;
        q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        drive_fifo();
        ticks(5);
        check("bp_pops", npop, 2);
        check("bp_rinc", {31'd0, RINC_O}, 32'd0);
        check("bp_valid", {31'd0, M_VALID_O}, 32'd1);
        check("bp_data", {24'd0, M_DATA_O}, 32'hA0);
        tick();
        check("bp_data_hold", {24'd0, M_DATA_O}, 32'hA0);
        M_READY_I = 1'b1;
        ticks(10);
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        check_rx("bp_order");
        check("bp_cnt", {28'd0, RD_CNT_O}, 32'd14);

        // 4: flush with two words held in the skid
        clear_stats();
        M_READY_I = 1'b0;
        q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8, 8'hB9};
        drive_fifo();
        ticks(2);
        check("fl_skid_pops", npop, 2);
        FLUSH_I = 1'b1;
        tick();
        FLUSH_I = 1'b0;
        check("fl_busy_on", {31'd0, BUSY_O}, 32'd1);
        npop = 0;
        ticks(8);
        check("fl_discard_pops", npop, 8);
        check("fl_fifo_empty", q.size(), 0);
        check("fl_busy_hold", {31'd0, BUSY_O}, 32'd1);
        tick();
        check("fl_busy_off", {31'd0, BUSY_O}, 32'd0);
        M_READY_I = 1'b1;
        ticks(4);
        exp_q = '{8'hB0, 8'hB1};
        check_rx("fl_skid_data");
        check("fl_cnt_wrap", {28'd0, RD_CNT_O}, 32'd0);

        // 5: REMPTY_I toggling every cycle
        clear_stats();
        q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        for (int i = 0; i < 20; i++) begin
            force_empty = i[0];
            drive_fifo();
            tick();
        end
        force_empty = 1'b0;
        drive_fifo();
        ticks(3);
        exp_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        check_rx("toggle_data");
        check("toggle_cnt", {28'd0, RD_CNT_O}, 32'd6);

        // 6: counter wrap over 17 words, then reset mid-stream
        RST_I = 1'b1;
        tick();
        RST_I = 1'b0;
        check("wrap_cnt_clear", {28'd0, RD_CNT_O}, 32'd0);
        clear_stats();
        exp_q.delete();
        for (int i = 0; i < 17; i++) begin
            q.push_back(8'h10 + 8'(i));
            exp_q.push_back(8'h10 + 8'(i));
        end
        drive_fifo();
        ticks(22);
        check_rx("wrap_data");
        check("wrap_cnt", {28'd0, RD_CNT_O}, 32'd1);
        q = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7};
        drive_fifo();
        ticks(4);
        check("mid_valid_pre", {31'd0, M_VALID_O}, 32'd1);
        RST_I = 1'b1;
        tick();
        RST_I = 1'b0;
        check("mid_valid", {31'd0, M_VALID_O}, 32'd0);
        check("mid_cnt", {28'd0, RD_CNT_O}, 32'd0);
        check("mid_rinc_idle", {31'd0, RINC_O}, 32'd0);
        check("mid_busy", {31'd0, BUSY_O}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
